delay_calc_arb: RTL and testbench
=================================

Name: delay_calc_arb

Overview:
- Shares one `delay_calc` unit between NUM_REQ requesters, e.g. several `delay_con` channel sequencers or focal-point lanes.
- Round-robin arbitration; the granted requester's coordinates are latched and a single `start` pulse is issued to `delay_calc`.
- Waits for `done`, then returns the 8-bit delay and a one-cycle ack to the owning requester.
- Sits between the per-lane delay controllers and the shared `delay_calc` instance.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- COORD_W, 16, width of each x/z coordinate.
- DELAY_W, 8, width of the returned delay.
- TIMEOUT_CYCLES, 1023, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- x_i_flat, z_i_flat, x_f_flat, z_f_flat  in  NUM_REQ*COORD_W each  per-requester operands; requester r uses slice [(r+1)*COORD_W-1 -: COORD_W]
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- delay_out  out  DELAY_W  result; valid while ack != 0
- busy  out  1  high in every state except IDLE
- calc_start  out  1  one-cycle start pulse to `delay_calc`
- calc_x_i, calc_z_i, calc_x_f, calc_z_f  out  COORD_W each  latched operands, stable from ISSUE through RESP
- calc_done  in  1  `done` from `delay_calc`
- calc_delay  in  DELAY_W  `delay_out` from `delay_calc`
- err  out  1  timeout flag, qualified by ack (tied 0 without the feature)

Behaviour:
- All outputs are registered.
- Reset values: ack=0, delay_out=0, busy=0, calc_start=0, calc_* operands=0, err=0, state=IDLE, rr_ptr=0, grant_idx=0.

State machine:
- IDLE: if req != 0, select the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. Latch grant_idx and that requester's four operands into calc_*. Next state ISSUE. If req == 0, stay.
- ISSUE: calc_start=1 for exactly this cycle. Next state WAIT.
- WAIT: on calc_done=1, capture calc_delay into delay_out. Next state RESP.
- RESP: ack[grant_idx]=1 for exactly this cycle. rr_ptr <= (grant_idx+1) mod NUM_REQ. Next state IDLE.

Timing:
- Latency from req sampled in IDLE to ack: 3 cycles + delay_calc compute time. ISSUE→WAIT is 1 cycle; WAIT lasts until calc_done; RESP is 1 cycle.
- busy is 1 in ISSUE, WAIT and RESP.

Handshake rules:
- Requester holds req and its operands stable until it samples ack=1.
- Requester clears req on the edge that ends RESP, so the following IDLE cycle does not see it.
- A req held high after ack is treated as a new request.
- Dropping req after grant does not abort; the operation completes and ack is still issued.
- Operand changes after the IDLE latch are ignored.

Boundary conditions:
- calc_done asserted in ISSUE: ignored (`delay_calc` cannot finish in 0 cycles).
- calc_done asserted in IDLE or RESP: ignored.
- All requesters asserted: served in order rr_ptr, rr_ptr+1, …; none starves. Worst-case wait is (NUM_REQ-1) full operations.
- rr_ptr wraps from NUM_REQ-1 to 0.
- reset in any state: returns to IDLE next cycle with reset values. In-flight result is discarded and no ack is issued; requesters re-request.
- delay_out holds its last value after RESP; it is only meaningful with ack.

Optional Feature:
- Macro: DELAY_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) is cleared on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without calc_done: delay_out = all-ones, go to RESP with err=1 alongside ack.
  - calc_done in the same cycle as timeout wins: normal result, err=0.
- Not defined: no counter; WAIT stays until calc_done; err tied 0.

Decomposition:
- Package `us_beam_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - COORD_W and DELAY_W defaults
  - an `rr_pick` function (priority select from a rotating pointer)
- One sub-module is natural: `rr_arbiter` — combinational round-robin picker with inputs req and rr_ptr, outputs grant_idx and any_req.
- FSM, operand latch and timeout counter stay in `delay_calc_arb`.

Test Plan:
- Single request: req=4'b0010, x_i=100, z_i=0, x_f=100, z_f=640, stub delay_calc done after 5 cycles with 8'd40 → calc_start one pulse 1 cycle after req, calc_* = those values; ack=4'b0010, delay_out=40 at RESP; busy=0 afterwards.
- All four requests held, stub returns requester index+10 → acks in order 0,1,2,3 with delay_out 10,11,12,13; then 0 again if still requested. Each operation uses only the granted operands.
- Fairness after wrap: rr_ptr=3, req=4'b1001 → grant 3 first, then 0.
- Reset in WAIT: assert reset 2 cycles after calc_start → no ack, busy=0, state IDLE next cycle. A subsequent req=4'b0100 is served normally.
- Late done: calc_done pulsed in IDLE and in ISSUE → no capture, no state change; only done in WAIT produces ack.
- With DELAY_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15, stub never asserts done → ack after exactly 15 WAIT cycles with err=1, delay_out=8'hFF. Without the macro → busy stays 1 indefinitely.

Source files
------------

// File: rtl/us_beam_pkg.sv
`default_nettype none
// ============================================================================
// Package    : us_beam_pkg
// Description: Shared types and helpers for the beamformer delay arbitration.
//              Provides the arbiter state encoding, operand/delay width
//              defaults and the rotating-pointer priority picker.
// Revision   : 1.0  initial release
// ============================================================================
package us_beam_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int DELAY_W_DEF = 8;

    // rr_pick works on a fixed-size vector so it can serve any NUM_REQ <= RR_MAX
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;
    localparam int RR_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    // First set bit of req[n-1:0], scanning ptr, ptr+1, ... modulo n.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_CNT_W-1:0] n,
        input logic [RR_CNT_W-1:0] ptr
    );
        logic [RR_IDX_W-1:0] pick;
        logic [RR_CNT_W-1:0] idx;
        logic [RR_CNT_W-1:0] k6;
        logic                found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            k6  = RR_CNT_W'(k);
            idx = ptr + k6;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k6 < n) && !found && req[idx[RR_IDX_W-1:0]]) begin
                pick  = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : rr_arbiter
// Description: Combinational round-robin picker. Returns the first requesting
//              index at or after rr_ptr_i (wrapping), plus an any-request flag.
//              Supports up to 32 requesters.
// Revision   : 1.0  initial release
// ============================================================================
module rr_arbiter
    import us_beam_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_req_o
);

    logic [RR_MAX-1:0]   req_w;
    logic [RR_IDX_W-1:0] pick_w;
    logic                unused_w;

    always_comb begin
        req_w              = '0;
        req_w[NUM_REQ-1:0] = req_i;
        pick_w             = rr_pick(req_w, RR_CNT_W'(NUM_REQ), RR_CNT_W'(rr_ptr_i));
    end

    assign grant_idx_o = pick_w[IDX_W-1:0];
    assign any_req_o   = |req_i;
    assign unused_w    = ^pick_w;

endmodule
`default_nettype wire

// File: rtl/delay_calc_arb.sv
`default_nettype none
// ============================================================================
// Module     : delay_calc_arb
// Description: Round-robin sharing of one delay_calc unit between NUM_REQ
//              requesters: latch operands, pulse start, wait for done, return
//              the delay with a one-cycle one-hot ack. Optional WAIT timeout
//              enabled with `define DELAY_ARB_TIMEOUT_EN.
// Revision   : 1.0  initial release
// ============================================================================
module delay_calc_arb
    import us_beam_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int COORD_W        = COORD_W_DEF,
    parameter int DELAY_W        = DELAY_W_DEF,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] x_i_flat,
    input  logic [NUM_REQ*COORD_W-1:0] z_i_flat,
    input  logic [NUM_REQ*COORD_W-1:0] x_f_flat,
    input  logic [NUM_REQ*COORD_W-1:0] z_f_flat,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DELAY_W-1:0]         delay_out,
    output logic                       busy,
    output logic                       calc_start,
    output logic [COORD_W-1:0]         calc_x_i,
    output logic [COORD_W-1:0]         calc_z_i,
    output logic [COORD_W-1:0]         calc_x_f,
    output logic [COORD_W-1:0]         calc_z_f,
    input  logic                       calc_done,
    input  logic [DELAY_W-1:0]         calc_delay,
    output logic                       err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DELAY_W-1:0]   dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic [COORD_W-1:0]   cxi_q, cxi_d, czi_q, czi_d, cxf_q, cxf_d, czf_q, czf_d;

    logic [IDX_W-1:0]     pick_w;
    logic                 any_req_w;
    logic                 tmo_hit_w;

    logic [COORD_W-1:0]   xi_w [NUM_REQ];
    logic [COORD_W-1:0]   zi_w [NUM_REQ];
    logic [COORD_W-1:0]   xf_w [NUM_REQ];
    logic [COORD_W-1:0]   zf_w [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign xi_w[r] = x_i_flat[(r+1)*COORD_W-1 -: COORD_W];
        assign zi_w[r] = z_i_flat[(r+1)*COORD_W-1 -: COORD_W];
        assign xf_w[r] = x_f_flat[(r+1)*COORD_W-1 -: COORD_W];
        assign zf_w[r] = z_f_flat[(r+1)*COORD_W-1 -: COORD_W];
    end

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr_arbiter (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (pick_w),
        .any_req_o   (any_req_w)
    );

`ifdef DELAY_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Cleared while in ISSUE so the first WAIT cycle sees zero.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_hit_w = (state_q == S_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_tmo_w;
    assign unused_tmo_w = TIMEOUT_CYCLES;
    assign tmo_hit_w    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        ack_d    = '0;
        dout_d   = dout_q;
        start_d  = 1'b0;
        err_d    = 1'b0;
        cxi_d    = cxi_q;
        czi_d    = czi_q;
        cxf_d    = cxf_q;
        czf_d    = czf_q;

        case (state_q)
            S_IDLE: begin
                if (any_req_w) begin
                    grant_d = pick_w;
                    cxi_d   = xi_w[pick_w];
                    czi_d   = zi_w[pick_w];
                    cxf_d   = xf_w[pick_w];
                    czf_d   = zf_w[pick_w];
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real result arriving on the timeout cycle takes precedence.
                if (calc_done) begin
                    dout_d         = calc_delay;
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_RESP;
                end else if (tmo_hit_w) begin
                    dout_d         = '1;
                    ack_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            cxi_q    <= '0;
            czi_q    <= '0;
            cxf_q    <= '0;
            czf_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            err_q    <= err_d;
            cxi_q    <= cxi_d;
            czi_q    <= czi_d;
            cxf_q    <= cxf_d;
            czf_q    <= czf_d;
        end
    end

    assign ack        = ack_q;
    assign delay_out  = dout_q;
    assign busy       = busy_q;
    assign calc_start = start_q;
    assign calc_x_i   = cxi_q;
    assign calc_z_i   = czi_q;
    assign calc_x_f   = cxf_q;
    assign calc_z_f   = czf_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_calc_arb.sv
`default_nettype none
// ============================================================================
// Module     : tb_delay_calc_arb
// Description: Self-checking bench for delay_calc_arb; the bench plays both the
//              requesters and the delay_calc stub against a round-robin model.
// Revision   : 1.0  initial release
// ============================================================================
module tb_delay_calc_arb;

    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*CW-1:0] xif, zif, xff, zff;
    logic [N-1:0]    ack;
    logic [DW-1:0]   delay_out;
    logic            busy, calc_start, calc_done, err;
    logic [CW-1:0]   calc_x_i, calc_z_i, calc_x_f, calc_z_f;
    logic [DW-1:0]   calc_delay;

    logic [CW-1:0]   m_xi [N];
    logic [CW-1:0]   m_zi [N];
    logic [CW-1:0]   m_xf [N];
    logic [CW-1:0]   m_zf [N];

    int n_checks = 0;
    int n_errors = 0;
    int exp_ptr  = 0;

    always #5 clk = ~clk;

    for (genvar r = 0; r < N; r++) begin : g_pack
        assign xif[r*CW +: CW] = m_xi[r];
        assign zif[r*CW +: CW] = m_zi[r];
        assign xff[r*CW +: CW] = m_xf[r];
        assign zff[r*CW +: CW] = m_zf[r];
    end

    delay_calc_arb #(
        .NUM_REQ        (N),
        .COORD_W        (CW),
        .DELAY_W        (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .x_i_flat   (xif),
        .z_i_flat   (zif),
        .x_f_flat   (xff),
        .z_f_flat   (zff),
        .ack        (ack),
        .delay_out  (delay_out),
        .busy       (busy),
        .calc_start (calc_start),
        .calc_x_i   (calc_x_i),
        .calc_z_i   (calc_z_i),
        .calc_x_f   (calc_x_f),
        .calc_z_f   (calc_z_f),
        .calc_done  (calc_done),
        .calc_delay (calc_delay),
        .err        (err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester at or after the pointer, modulo N.
    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic scramble_ops();
        for (int r = 0; r < N; r++) begin
            m_xi[r] = 16'($urandom);
            m_zi[r] = 16'($urandom);
            m_xf[r] = 16'($urandom);
            m_zf[r] = 16'($urandom);
        end
    endtask

    // One full transaction starting with the DUT in IDLE and req already driven.
    task automatic serve(input int lat, input logic [DW-1:0] dval, input bit spur, output int g);
        logic [CW-1:0] sxi, szi, sxf, szf;
        logic [N-1:0]  oh;
        g = model_pick(req, exp_ptr);
        if (g < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL serve_setup: got req=0 expected nonzero");
            g = 0;
            return;
        end
        sxi = m_xi[g]; szi = m_zi[g]; sxf = m_xf[g]; szf = m_zf[g];
        oh = '0;
        oh[g] = 1'b1;
        calc_done  = spur;
        calc_delay = ~dval;
        tick();                                   // ISSUE
        check("start_pulse", calc_start, 1'b1);
        check("busy_issue", busy, 1'b1);
        check("ack_issue", ack, '0);
        check("op_x_i", calc_x_i, sxi);
        check("op_z_i", calc_z_i, szi);
        check("op_x_f", calc_x_f, sxf);
        check("op_z_f", calc_z_f, szf);
        scramble_ops();
        calc_done = spur;
        tick();                                   // WAIT cycle 1
        check("start_once", calc_start, 1'b0);
        check("busy_wait", busy, 1'b1);
        check("ack_wait1", ack, '0);
        calc_done = 1'b0;
        for (int i = 1; i < lat; i++) begin
            tick();
            check("ack_wait", ack, '0);
        end
        calc_done  = 1'b1;
        calc_delay = dval;
        tick();                                   // RESP
        check("ack_resp", ack, oh);
        check("delay_resp", delay_out, dval);
        check("err_resp", err, 1'b0);
        check("busy_resp", busy, 1'b1);
        check("op_x_i_hold", calc_x_i, sxi);
        check("op_z_f_hold", calc_z_f, szf);
        calc_done  = spur;
        calc_delay = ~dval;
        req[g]     = 1'b0;
        tick();                                   // IDLE
        check("ack_clear", ack, '0);
        check("busy_idle", busy, 1'b0);
        check("delay_hold", delay_out, dval);
        calc_done = 1'b0;
        exp_ptr   = (g + 1) % N;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        exp_ptr = 0;
    endtask

    initial begin
        int g;
        logic [DW-1:0] dv;
        reset      = 1'b1;
        req        = '0;
        calc_done  = 1'b0;
        calc_delay = '0;
        for (int r = 0; r < N; r++) begin
            m_xi[r] = '0; m_zi[r] = '0; m_xf[r] = '0; m_zf[r] = '0;
        end
        do_reset();
        check("rst_ack", ack, '0);
        check("rst_delay", delay_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", calc_start, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ops", {calc_x_i, calc_z_i, calc_x_f, calc_z_f}, '0);

        // Single request from requester 1
        m_xi[1] = 16'd100; m_zi[1] = 16'd0; m_xf[1] = 16'd100; m_zf[1] = 16'd640;
        req = 4'b0010;
        serve(5, 8'd40, 1'b0, g);

        // All four held: served 0,1,2,3 then 0 again
        do_reset();
        scramble_ops();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = model_pick(req, exp_ptr);
            dv = 8'(g + 10);
            serve(3, dv, 1'b0, g);
            req = 4'b1111;
        end

        // Fairness across the wrap: pointer at 3, req 1001
        do_reset();
        req = 4'b0100;
        serve(2, 8'h33, 1'b0, g);
        req = 4'b1001;
        serve(2, 8'h44, 1'b0, g);
        serve(2, 8'h55, 1'b0, g);

        // Reset two cycles after calc_start discards the operation
        req = 4'b0100;
        tick();
        check("rw_start", calc_start, 1'b1);
        tick();
        tick();
        reset     = 1'b1;
        calc_done = 1'b1;
        calc_delay = 8'hA5;
        tick();
        check("rw_busy", busy, 1'b0);
        check("rw_ack", ack, '0);
        check("rw_delay", delay_out, '0);
        reset     = 1'b0;
        calc_done = 1'b0;
        exp_ptr   = 0;
        req       = '0;
        tick();
        check("rw_idle_busy", busy, 1'b0);
        check("rw_idle_ack", ack, '0);
        req = 4'b0100;
        serve(4, 8'h21, 1'b1, g);

        // Stray done while idle is ignored
        req        = '0;
        calc_done  = 1'b1;
        calc_delay = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_busy", busy, 1'b0);
            check("stray_ack", ack, '0);
            check("stray_delay", delay_out, 8'h21);
        end
        calc_done = 1'b0;

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                req       = '0;
                calc_done = 1'($urandom_range(0, 1));
                tick();
                check("gap_start", calc_start, 1'b0);
                check("gap_busy", busy, 1'b0);
                calc_done = 1'b0;
            end
            req = req | 4'($urandom_range(1, 15));
            scramble_ops();
            serve(int'($urandom_range(1, 8)), 8'($urandom), 1'($urandom_range(0, 1)), g);
        end

`ifdef DELAY_ARB_TIMEOUT_EN
        // Stub never finishes: timeout after exactly TMO WAIT cycles
        req = 4'b0001;
        g = model_pick(req, exp_ptr);
        tick();
        check("tmo_start", calc_start, 1'b1);
        for (int i = 0; i < TMO; i++) begin
            tick();
            check("tmo_wait_ack", ack, '0);
        end
        req[0] = 1'b0;
        tick();
        check("tmo_ack", ack, 4'b0001);
        check("tmo_err", err, 1'b1);
        check("tmo_delay", delay_out, 8'hFF);
        tick();
        check("tmo_err_clear", err, 1'b0);
        check("tmo_busy", busy, 1'b0);
        exp_ptr = (g + 1) % N;
        // done on the timeout cycle wins
        req = 4'b0010;
        serve(TMO, 8'h5A, 1'b0, g);
`else
        // Without the timeout the arbiter waits forever
        req = 4'b0001;
        tick();
        check("notmo_start", calc_start, 1'b1);
        req = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i % 50 == 49) begin
                check("notmo_busy", busy, 1'b1);
                check("notmo_ack", ack, '0);
                check("notmo_err", err, 1'b0);
            end
        end
        do_reset();
        check("notmo_rst_busy", busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
